sequence_memory: RTL and testbench
==================================

// Module: sequence_memory
// PURPOSE
//  Word store that serves the sequencer's read port (r_en/r_addr -> r_data/r_ready handshake)
//  with a fixed, parameterised read latency. Filled from an upstream byte loader through a
//  pointer-based write stream. Sits directly upstream of the sequencer in the clock domain.
// PARAMETERS
//  WORD_SIZE     8   width of each stored word and of r_data/load_data
//  ADDRESS_SIZE  4   width of r_addr and load_ptr
//  MEMORY_QTY    16  number of words; must be <= 2**ADDRESS_SIZE
//  READ_LATENCY  2   clock edges from read acceptance to r_ready high; must be >= 1
// PORTS
//  clock        in   1             system clock, all state on rising edge
//  reset        in   1             asynchronous, active-high
//  r_en         in   1             read request, level, held by requester until r_ready seen
//  r_addr       in   ADDRESS_SIZE  read address, sampled at acceptance edge only
//  r_data       out  WORD_SIZE     read data, valid while r_ready=1 after a completed read
//  r_ready      out  1             1 = idle or data valid; 0 = read in progress
//  load_start   in   1             pulse: restart loading at address 0, clear load_full
//  load_valid   in   1             load_data valid this cycle; writes mem[load_ptr]
//  load_data    in   WORD_SIZE     byte/word to store
//  load_ptr     out  ADDRESS_SIZE  next write address
//  load_full    out  1             set once all MEMORY_QTY words have been written
// BEHAVIOUR
//  Reset (async): all words = 0, r_data = 0, state = IDLE, r_ready = 1, load_ptr = 0, load_full = 0.
//  Read FSM states IDLE, WAIT, DONE; latency counter width >= clog2(READ_LATENCY+1).
//   IDLE: r_ready = !r_en (combinational drop the same cycle r_en rises, so a requester never
//     samples a stale ready). Edge with r_en=1 = acceptance edge: latch r_addr, counter loaded,
//     -> WAIT (or straight to DONE with capture if READ_LATENCY=1).
//   WAIT: r_ready = 0. Counter decrements each edge; on the READ_LATENCY-th edge after
//     acceptance, r_data <= mem[latched addr], -> DONE. r_en=0 sampled in WAIT: abort,
//     -> IDLE, r_data unchanged, no capture.
//   DONE: r_ready = 1, r_data held. Stays while r_en=1 (no re-trigger); r_en=0 sampled -> IDLE.
//     Requester must drop r_en for >= 1 edge between reads.
//  Latched address >= MEMORY_QTY: read completes normally, r_data = 0.
//  r_addr changes after acceptance are ignored.
//  Load: edge with load_valid=1 writes mem[load_ptr] <= load_data, load_ptr increments;
//   load_ptr = MEMORY_QTY-1 wraps to 0 and sets load_full (sticky). Writes continue after
//   full, overwriting from address 0.
//  load_start=1 alone: load_ptr <= 0, load_full <= 0, no write.
//  load_start and load_valid same edge: write to address 0, load_ptr <= 1, load_full <= 0.
//  Read/write collision: write to the latched address on the capture edge -> r_data gets the
//   OLD word (read-before-write); the new word is visible to later reads.
//  Loading is independent of the read FSM; both may be active in the same cycle.
//  Reset mid-read or mid-load: immediate return to reset values; in-flight read is discarded.
// TESTING
//  1 Assert/release reset -> r_ready=1, r_data=0x00, load_ptr=0, load_full=0; read of any
//    address returns 0x00.
//  2 load_start, then 16 load_valid beats 0x10..0x1F -> load_ptr back to 0, load_full=1 after
//    16th beat; mem[k] = 0x10+k.
//  3 After 2, r_en=1, r_addr=5 -> r_ready=0 in the same cycle, r_ready=1 after exactly 2 edges
//    past acceptance, r_data=0x15; held until r_en drops, then r_ready stays 1.
//  4 r_en=1, r_addr=9, drop r_en after 1 edge -> FSM back in IDLE, r_data keeps previous
//    value (0x15), no r_ready pulse; next full read of 9 returns 0x19.
//  5 Read addr 3 with load writing 0xA3 to addr 3 on the capture edge -> r_data=0x13;
//    subsequent read of 3 -> 0xA3.
//  6 Assert reset during WAIT of a read of addr 7 -> r_ready=1, r_data=0x00 at once, all words
//    0; load_start+load_valid same edge with 0x55 -> mem[0]=0x55, load_ptr=1.

Source files
------------

// File: rtl/sequence_memory.sv
// Word store feeding the sequencer read port with a fixed read latency,
// filled by an upstream loader through an auto-incrementing write pointer.
module sequence_memory #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int MEMORY_QTY   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    r_en_i,
    input  logic [ADDRESS_SIZE-1:0] r_addr_i,
    output logic [WORD_SIZE-1:0]    r_data_o,
    output logic                    r_ready_o,
    input  logic                    load_start_i,
    input  logic                    load_valid_i,
    input  logic [WORD_SIZE-1:0]    load_data_i,
    output logic [ADDRESS_SIZE-1:0] load_ptr_o,
    output logic                    load_full_o
);

    localparam int                      CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_LAST = ADDRESS_SIZE'(MEMORY_QTY - 1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE  = ADDRESS_SIZE'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]    r_data_q, r_data_d;
    logic [ADDRESS_SIZE-1:0] load_ptr_q, load_ptr_d;
    logic                    load_full_q, load_full_d;
    logic [WORD_SIZE-1:0]    mem_q [MEMORY_QTY];

    logic                    wr_en;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [ADDRESS_SIZE-1:0] cap_addr;
    logic [WORD_SIZE-1:0]    cap_word;

    // With a one-edge latency the capture happens on the acceptance edge itself.
    assign cap_addr = (state_q == ST_IDLE) ? r_addr_i : addr_q;
    assign cap_word = (int'(cap_addr) < MEMORY_QTY) ? mem_q[cap_addr] : '0;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        r_data_d  = r_data_q;
        r_ready_o = 1'b1;
        case (state_q)
            ST_IDLE: begin
                r_ready_o = !r_en_i;
                if (r_en_i) begin
                    addr_d = r_addr_i;
                    if (READ_LATENCY == 1) begin
                        r_data_d = cap_word;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                r_ready_o = 1'b0;
                if (!r_en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    r_data_d = cap_word;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (!r_en_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ptr_d  = load_ptr_q;
        load_full_d = load_full_q;
        wr_en       = 1'b0;
        wr_addr     = load_ptr_q;
        if (load_start_i) begin
            load_full_d = 1'b0;
            load_ptr_d  = '0;
            wr_addr     = '0;
            if (load_valid_i) begin
                wr_en      = 1'b1;
                load_ptr_d = (PTR_LAST == '0) ? '0 : PTR_ONE;
            end
        end else if (load_valid_i) begin
            wr_en = 1'b1;
            if (load_ptr_q == PTR_LAST) begin
                load_ptr_d  = '0;
                load_full_d = 1'b1;
            end else begin
                load_ptr_d = load_ptr_q + PTR_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            r_data_q    <= '0;
            load_ptr_q  <= '0;
            load_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            r_data_q    <= r_data_d;
            load_ptr_q  <= load_ptr_d;
            load_full_q <= load_full_d;
        end
    end

    // NOTE: the words must read back as zero after reset, so the array is built from resettable flops, not a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEMORY_QTY; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= load_data_i;
        end
    end

    assign r_data_o    = r_data_q;
    assign load_ptr_o  = load_ptr_q;
    assign load_full_o = load_full_q;

endmodule

// File: tb/tb_sequence_memory.sv
// Directed bench for sequence_memory: a transaction-level model is compared
// every cycle, plus literal expectations for each scenario.
module tb_sequence_memory;

    localparam int LAT     = 2;
    localparam int MEM_QTY = 16;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       r_en       = 1'b0;
    logic [3:0] r_addr     = '0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data  = '0;
    logic [7:0] r_data;
    logic       r_ready;
    logic [3:0] load_ptr;
    logic       load_full;

    int tests = 0;
    int fails = 0;

    sequence_memory #(
        .WORD_SIZE   (8),
        .ADDRESS_SIZE(4),
        .MEMORY_QTY  (MEM_QTY),
        .READ_LATENCY(LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .r_en_i      (r_en),
        .r_addr_i    (r_addr),
        .r_data_o    (r_data),
        .r_ready_o   (r_ready),
        .load_start_i(load_start),
        .load_valid_i(load_valid),
        .load_data_i (load_data),
        .load_ptr_o  (load_ptr),
        .load_full_o (load_full)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a read is "busy" for LAT edges after acceptance,
    // then "done" holding its word until the requester lets go.
    logic [7:0] m_mem [MEM_QTY];
    int         m_ptr   = 0;
    logic       m_full  = 1'b0;
    logic [7:0] m_rdata = '0;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;
    int         m_age   = 0;
    int         m_addr  = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_QTY; i++) m_mem[i] <= '0;
            m_ptr <= 0; m_full <= 1'b0; m_rdata <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_age <= 0; m_addr <= 0;
        end else begin
            if (m_busy) begin
                if (!r_en) m_busy <= 1'b0;
                else if (m_age + 1 == LAT) begin
                    m_rdata <= (m_addr < MEM_QTY) ? m_mem[m_addr] : 8'h00;
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                end else m_age <= m_age + 1;
            end else if (m_done) begin
                if (!r_en) m_done <= 1'b0;
            end else if (r_en) begin
                m_addr <= int'(r_addr);
                m_age  <= 0;
                m_busy <= 1'b1;
            end
            if (load_start) begin
                m_full <= 1'b0;
                if (load_valid) begin
                    m_mem[0] <= load_data;
                    m_ptr    <= 1;
                end else m_ptr <= 0;
            end else if (load_valid) begin
                m_mem[m_ptr] <= load_data;
                if (m_ptr == MEM_QTY - 1) m_full <= 1'b1;
                m_ptr <= (m_ptr + 1) % MEM_QTY;
            end
        end
    end

    always @(negedge clock) begin
        #1;
        check("cmp_r_ready", r_ready, m_busy ? 1'b0 : (m_done ? 1'b1 : !r_en));
        check("cmp_r_data", r_data, m_rdata);
        check("cmp_load_ptr", load_ptr, m_ptr[3:0]);
        check("cmp_load_full", load_full, m_full);
    end

    task automatic do_read(input logic [3:0] addr, input logic [7:0] exp);
        int edges;
        @(negedge clock);
        r_en = 1'b1;
        r_addr = addr;
        #1;
        check("ready_drop", r_ready, 1'b0);
        edges = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
            if (edges == 1) r_addr = ~addr;
        end while (!r_ready && edges < 20);
        check("read_latency", edges, LAT + 1);
        check("read_data", r_data, exp);
        @(posedge clock);
        #1;
        check("hold_ready", r_ready, 1'b1);
        check("hold_data", r_data, exp);
        @(negedge clock);
        r_en = 1'b0;
        @(posedge clock);
        #1;
        check("idle_ready", r_ready, 1'b1);
        check("idle_data", r_data, exp);
    endtask

    task automatic load_beat(input logic start, input logic valid, input logic [7:0] d);
        @(negedge clock);
        load_start = start;
        load_valid = valid;
        load_data  = d;
        @(posedge clock);
        #1;
        load_start = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", r_ready, 1'b1);
        check("rst_data", r_data, 8'h00);
        check("rst_ptr", load_ptr, 4'd0);
        check("rst_full", load_full, 1'b0);
        do_read(4'hC, 8'h00);

        load_beat(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            load_beat(1'b0, 1'b1, 8'(8'h10 + k));
            if (k == 14) check("full_before_last", load_full, 1'b0);
        end
        check("fill_ptr", load_ptr, 4'd0);
        check("fill_full", load_full, 1'b1);

        do_read(4'd5, 8'h15);

        @(negedge clock);
        r_en = 1'b1;
        r_addr = 4'd9;
        @(posedge clock);
        #1;
        check("abort_wait_ready", r_ready, 1'b0);
        @(negedge clock);
        r_en = 1'b0;
        @(posedge clock);
        #1;
        check("abort_ready", r_ready, 1'b1);
        check("abort_data", r_data, 8'h15);
        do_read(4'd9, 8'h19);

        load_beat(1'b1, 1'b0, 8'h00);
        check("restart_full", load_full, 1'b0);
        load_beat(1'b0, 1'b1, 8'h10);
        load_beat(1'b0, 1'b1, 8'h11);
        load_beat(1'b0, 1'b1, 8'h12);
        check("coll_ptr", load_ptr, 4'd3);
        @(negedge clock);
        r_en = 1'b1;
        r_addr = 4'd3;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        load_valid = 1'b1;
        load_data  = 8'hA3;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        check("coll_ready", r_ready, 1'b1);
        check("coll_old_data", r_data, 8'h13);
        check("coll_ptr_after", load_ptr, 4'd4);
        @(negedge clock);
        r_en = 1'b0;
        @(posedge clock);
        #1;
        do_read(4'd3, 8'hA3);

        @(negedge clock);
        r_en = 1'b1;
        r_addr = 4'd7;
        @(posedge clock);
        #1;
        check("rst_mid_wait", r_ready, 1'b0);
        r_en  = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_ready", r_ready, 1'b1);
        check("rst_mid_data", r_data, 8'h00);
        check("rst_mid_ptr", load_ptr, 4'd0);
        check("rst_mid_full", load_full, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        load_beat(1'b1, 1'b1, 8'h55);
        check("startvalid_ptr", load_ptr, 4'd1);
        check("startvalid_full", load_full, 1'b0);
        do_read(4'd0, 8'h55);
        do_read(4'd7, 8'h00);
        do_read(4'd1, 8'h00);

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
